// File: rtl/trace_pkg.sv
// Shared definitions for the CPU write-trace buffer.
// Entries are packed {kind, stamp, pc, addr, data}, with data at bit 0.
package trace_pkg;

    localparam int KIND_W = 2;
    localparam int WORD_W = 32;

    localparam logic [KIND_W-1:0] KIND_REG = 2'b01;
    localparam logic [KIND_W-1:0] KIND_MEM = 2'b10;

    localparam int DATA_LSB  = 0;
    localparam int ADDR_LSB  = DATA_LSB + WORD_W;
    localparam int PC_LSB    = ADDR_LSB + WORD_W;
    localparam int STAMP_LSB = PC_LSB + WORD_W;

    // ENTRY_W = 2 + CYCLE_W + 96; the stamp width is a parameter of the top.
    function automatic int entry_width(input int cycle_w);
        return KIND_W + cycle_w + 3 * WORD_W;
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// FIFO with two ordered write ports and one read port.
// Port 0 is written before port 1; i_push_n (0..2) says how many ports are used.
module trace_fifo_2w1r #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 130,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       i_push_n,
    input  logic [WIDTH-1:0] i_wr_data0,
    input  logic [WIDTH-1:0] i_wr_data1,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_wr_ptr_1;

    assign w_wr_ptr_1 = r_wr_ptr + PTR_W'(1);

    // NOTE: storage has no reset; validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        if (i_push_n != 2'd0) r_mem[r_wr_ptr]   <= i_wr_data0;
        if (i_push_n == 2'd2) r_mem[w_wr_ptr_1] <= i_wr_data1;
    end

    // NOTE: state registers use non-blocking assignment so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count  <= r_count + CNT_W'(i_push_n) - CNT_W'(i_pop);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Snoops register-file and data-memory writes of the core and logs each one,
// cycle-stamped, into a FIFO drained through a valid/ready stream.
module cpu_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 32,
    parameter int DROP_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trace_en,
    input  logic [31:0]        pc,
    input  logic               register_we3,
    input  logic [4:0]         register_a3,
    input  logic [31:0]        register_wd3,
    input  logic               data_memory_we,
    input  logic [31:0]        data_memory_a,
    input  logic [31:0]        data_memory_wd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_kind,
    output logic [CYCLE_W-1:0] out_cycle,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_addr,
    output logic [31:0]        out_data,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_count
);

    localparam int ENTRY_W  = entry_width(CYCLE_W);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int KIND_LSB = STAMP_LSB + CYCLE_W;

    logic [CYCLE_W-1:0] r_cycle;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_count;

    logic               w_reg_ev;
    logic               w_mem_ev;
    logic [ENTRY_W-1:0] w_reg_entry;
    logic [ENTRY_W-1:0] w_mem_entry;
    logic [ENTRY_W-1:0] w_slot0;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_free;
    logic [1:0]         w_n_ev;
    logic [1:0]         w_push_n;
    logic [1:0]         w_n_drop;
    logic [DROP_W:0]    w_drop_sum;
    logic               w_pop;

    assign w_reg_ev = trace_en && register_we3 && (register_a3 != 5'd0);
    assign w_mem_ev = trace_en && data_memory_we;

    assign w_reg_entry = {KIND_REG, r_cycle, pc, 27'b0, register_a3, register_wd3};
    assign w_mem_entry = {KIND_MEM, r_cycle, pc, data_memory_a, data_memory_wd};

    // Credit comes from the registered count only; a same-cycle pop frees nothing.
    assign w_free = CNT_W'(DEPTH) - w_count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_n_ev   = {1'b0, w_reg_ev} + {1'b0, w_mem_ev};
        w_push_n = w_n_ev;
        if (w_free == '0)
            w_push_n = 2'd0;
        else if ((w_free == CNT_W'(1)) && (w_n_ev == 2'd2))
            w_push_n = 2'd1;
        w_n_drop = w_n_ev - w_push_n;
        w_slot0  = w_reg_ev ? w_reg_entry : w_mem_entry;
    end

    assign w_drop_sum = {1'b0, r_drop_count} + (DROP_W + 1)'(w_n_drop);
    assign w_pop      = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_cycle <= r_cycle + CYCLE_W'(1);
            if (w_n_drop != 2'd0) begin
                r_overflow   <= 1'b1;
                r_drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
            end
        end
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_n   (w_push_n),
        .i_wr_data0 (w_slot0),
        .i_wr_data1 (w_mem_entry),
        .i_pop      (w_pop),
        .o_rd_data  (w_head),
        .o_count    (w_count)
    );

    assign out_valid  = (w_count != '0);
    assign out_kind   = out_valid ? w_head[KIND_LSB +: KIND_W]   : '0;
    assign out_cycle  = out_valid ? w_head[STAMP_LSB +: CYCLE_W] : '0;
    assign out_pc     = out_valid ? w_head[PC_LSB +: WORD_W]     : '0;
    assign out_addr   = out_valid ? w_head[ADDR_LSB +: WORD_W]   : '0;
    assign out_data   = out_valid ? w_head[DATA_LSB +: WORD_W]   : '0;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: a queue-level model predicts accepted
// entries and drops; a negedge monitor compares every handshake and status output.
module tb_cpu_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CYCLE_W = 32;
    localparam int DROP_W  = 4;
    localparam int DMAX    = (1 << DROP_W) - 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cycle;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    logic              clk;
    logic              reset;
    logic              trace_en;
    logic [31:0]       pc;
    logic              register_we3;
    logic [4:0]        register_a3;
    logic [31:0]       register_wd3;
    logic              data_memory_we;
    logic [31:0]       data_memory_a;
    logic [31:0]       data_memory_wd;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_kind;
    logic [CYCLE_W-1:0] out_cycle;
    logic [31:0]       out_pc;
    logic [31:0]       out_addr;
    logic [31:0]       out_data;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    cpu_trace_buffer #(
        .DEPTH   (DEPTH),
        .CYCLE_W (CYCLE_W),
        .DROP_W  (DROP_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trace_en       (trace_en),
        .pc             (pc),
        .register_we3   (register_we3),
        .register_a3    (register_a3),
        .register_wd3   (register_wd3),
        .data_memory_we (data_memory_we),
        .data_memory_a  (data_memory_a),
        .data_memory_wd (data_memory_wd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_kind       (out_kind),
        .out_cycle      (out_cycle),
        .out_pc         (out_pc),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: queued entries, occupancy, cycle stamp, drop accounting.
    entry_t      exp_q[$];
    int          mcnt;
    logic [31:0] mcycle;
    int          mdrop;
    bit          movf;
    bit          mon_en;

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_drop();
        movf = 1'b1;
        if (mdrop < DMAX) mdrop++;
    endtask

    always @(posedge clk) begin : model
        entry_t ev[$];
        entry_t e;
        bit     do_pop;
        if (!reset) begin
            ev.delete();
            if (trace_en && register_we3 && register_a3 != 5'd0) begin
                e = '{kind: KIND_REG, cycle: mcycle, pc: pc, addr: {27'b0, register_a3}, data: register_wd3};
                ev.push_back(e);
            end
            if (trace_en && data_memory_we) begin
                e = '{kind: KIND_MEM, cycle: mcycle, pc: pc, addr: data_memory_a, data: data_memory_wd};
                ev.push_back(e);
            end
            do_pop = (mcnt > 0) && out_ready;
            foreach (ev[k]) begin
                if (mcnt < DEPTH) begin
                    exp_q.push_back(ev[k]);
                    mcnt++;
                end else begin
                    model_drop();
                end
            end
            if (do_pop) mcnt--;
            mcycle = mcycle + 32'd1;
        end
    end

    always @(negedge clk) begin : monitor
        entry_t got;
        entry_t exp;
        if (mon_en && !reset) begin
            got = {out_kind, out_cycle, out_pc, out_addr, out_data};
            check("out_valid", out_valid, mcnt != 0);
            check("overflow", overflow, movf);
            check("drop_count", drop_count, mdrop);
            if (out_valid && out_ready) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("sb_entry", got, exp);
            end else if (!out_valid) begin
                check("idle_fields", got, 0);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_events();
        register_we3   = 1'b0;
        register_a3    = 5'd0;
        register_wd3   = 32'd0;
        data_memory_we = 1'b0;
        data_memory_a  = 32'd0;
        data_memory_wd = 32'd0;
    endtask

    task automatic set_reg(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] p);
        register_we3 = 1'b1;
        register_a3  = a3;
        register_wd3 = wd;
        pc           = p;
    endtask

    task automatic set_mem(input logic [31:0] a, input logic [31:0] wd);
        data_memory_we = 1'b1;
        data_memory_a  = a;
        data_memory_wd = wd;
    endtask

    logic [31:0] base;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mcnt     = 0;
        mcycle   = 32'd0;
        mdrop    = 0;
        movf     = 1'b0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        trace_en = 1'b1;
        pc       = 32'd0;
        out_ready = 1'b0;
        clear_events();

        #3;
        check("rst_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_fields", {out_kind, out_cycle, out_pc, out_addr, out_data}, 0);

        // First edge after reset: $8 = 5 at pc 0.
        #9;
        reset  = 1'b0;
        mon_en = 1'b1;
        out_ready = 1'b1;
        set_reg(5'd8, 32'd5, 32'h0);
        step();
        clear_events();
        check("first_valid", out_valid, 1);
        check("first_kind", out_kind, 2'b01);
        check("first_cycle", out_cycle, 0);
        check("first_pc", out_pc, 0);
        check("first_addr", out_addr, 8);
        check("first_data", out_data, 5);
        step();
        check("first_popped", out_valid, 0);

        // Writes to $0 are never traced.
        set_reg(5'd0, 32'd7, 32'h8);
        step();
        clear_events();
        step();
        check("r0_valid", out_valid, 0);
        check("r0_drop", drop_count, 0);

        // Store sampled at the 6th edge after reset.
        step();
        pc = 32'h14;
        set_mem(32'h10, 32'd42);
        step();
        clear_events();
        check("sw_kind", out_kind, 2'b10);
        check("sw_addr", out_addr, 32'h10);
        check("sw_data", out_data, 42);
        check("sw_pc", out_pc, 32'h14);
        check("sw_cycle", out_cycle, 5);
        step();

        // 18 register writes with the consumer stalled: 16 held, 2 dropped.
        out_ready = 1'b0;
        base = mcycle;
        for (int i = 0; i < 18; i++) begin
            set_reg(5'((i % 31) + 1), $urandom, 32'(i * 4));
            step();
        end
        clear_events();
        check("full_valid", out_valid, 1);
        check("full_overflow", overflow, 1);
        check("full_drop", drop_count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_stamp", out_cycle, base + 32'(i));
            step();
        end
        check("drained", out_valid, 0);

        // Paired events at count 15, then at count 14.
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            set_reg(5'd3, 32'(i), 32'h100);
            step();
        end
        set_reg(5'd9, 32'hAAAA, 32'h200);
        set_mem(32'h40, 32'hBBBB);
        step();
        clear_events();
        check("c15_drop", drop_count, 3);
        out_ready = 1'b1;
        step(2);
        out_ready = 1'b0;
        set_reg(5'd10, 32'hCCCC, 32'h204);
        set_mem(32'h44, 32'hDDDD);
        step();
        check("c14_drop", drop_count, 3);
        // Full FIFO: both events of a pair dropped, then saturation.
        step();
        check("c16_drop", drop_count, 5);
        step(6);
        clear_events();
        check("drop_sat", drop_count, DMAX);
        check("sat_overflow", overflow, 1);
        out_ready = 1'b1;
        step(20);
        check("drained2", out_valid, 0);

        // Reset pulse between edges with 5 entries queued.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_reg(5'd4, 32'(i), 32'h300);
            step();
        end
        clear_events();
        check("pre_rst_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        mcnt   = 0;
        mcycle = 32'd0;
        mdrop  = 0;
        movf   = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_drop", drop_count, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        set_reg(5'd5, 32'h55, 32'h400);
        step();
        clear_events();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_cycle", out_cycle, 0);
        step();

        // Randomised traffic with varying consumer back-pressure.
        for (int i = 0; i < 3000; i++) begin
            trace_en       = ($urandom_range(0, 9) != 0);
            pc             = $urandom & 32'hFFFF_FFFC;
            register_we3   = $urandom_range(0, 1) == 1;
            register_a3    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            register_wd3   = $urandom;
            data_memory_we = ($urandom_range(0, 2) == 0);
            data_memory_a  = $urandom;
            data_memory_wd = $urandom;
            out_ready      = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                  : ($urandom_range(0, 3) == 0);
            step();
        end
        clear_events();
        out_ready = 1'b1;
        step(DEPTH + 2);
        check("final_empty", out_valid, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Downstream observer of the single-cycle MIPS core. It snoops the register-file write port and the data-memory write port on every clock.
- Each architectural write becomes a timestamped trace entry in an internal FIFO. Entries are drained through a valid/ready stream.
- Replaces end-of-run register and memory dumps with an ordered per-cycle write log for benches and debug export.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥ 2.
- CYCLE_W, 32, width of the free-running cycle stamp.
- DROP_W, 16, width of the saturating dropped-event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- trace_en  in  1  capture enable; when 0, no events are captured and none are counted as dropped.
- pc  in  32  PC of the instruction retiring this cycle.
- register_we3  in  1  register write enable snooped from the core.
- register_a3  in  5  register write index.
- register_wd3  in  32  register write data.
- data_memory_we  in  1  data memory write enable.
- data_memory_a  in  32  data memory byte address.
- data_memory_wd  in  32  data memory write data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_kind  out  2  01 = register write, 10 = memory write.
- out_cycle  out  CYCLE_W  cycle stamp of the event.
- out_pc  out  32  PC of the event.
- out_addr  out  32  register index zero-extended, or memory address.
- out_data  out  32  written value.
- overflow  out  1  sticky; set by the first dropped event.
- drop_count  out  DROP_W  number of dropped events, saturating.

Behaviour:
- Reset (async, active-high):
  - cycle counter, FIFO pointers and occupancy count cleared to 0.
  - overflow = 0, drop_count = 0, out_valid = 0.
  - out_kind/out_cycle/out_pc/out_addr/out_data = 0 while empty.
  - Reset asserted mid-drain discards every entry.
- Cycle counter:
  - increments every clock out of reset and wraps modulo 2^CYCLE_W.
  - An event sampled at an edge is stamped with the counter value before that edge's increment. The first edge after reset stamps 0.
- Event detection (sampled at the rising edge, only when trace_en = 1):
  - reg event = register_we3 && register_a3 != 0; writes to $0 are never traced.
  - mem event = data_memory_we.
- Entry contents:
  - reg entry = {01, stamp, pc, {27'b0, a3}, wd3}.
  - mem entry = {10, stamp, pc, data_memory_a, data_memory_wd}.
- Push rules:
  - free = DEPTH − count, where count is the registered value. A pop in the same cycle does not add credit.
  - Single event with free ≥ 1: push it. With free = 0: drop it.
  - Both events in one cycle: reg entry is ordered first, mem entry second.
    - free ≥ 2: push both in the same cycle.
    - free = 1: push reg, drop mem.
    - free = 0: drop both; drop_count += 2.
- Drop accounting:
  - Every dropped event sets overflow and increments drop_count by 1 per event.
  - drop_count saturates at all-ones. overflow clears only on reset.
- Pop:
  - out_valid = (count != 0). Output fields are driven combinationally from the head entry.
  - Handshake: pop when out_valid && out_ready. out_ready while empty has no effect.
- Count update: count_next = count + pushes − pop, in the range 0..DEPTH.
- Pointers: wrap modulo DEPTH. With two pushes, the write pointer advances by 2.
- Latency: an event sampled at edge N is visible on out_valid after edge N (one cycle). No bypass from input to output.

Decomposition:
- Shared package (trace_pkg):
  - KIND_REG = 2'b01, KIND_MEM = 2'b10.
  - Entry field widths and offsets; ENTRY_W = 2 + CYCLE_W + 96.
- One sub-module: trace_fifo_2w1r.
  - Parameterised DEPTH × ENTRY_W storage.
  - Two ordered write ports, one read port.
  - Registered count and pointers.
  - Same async active-high reset.
- Top level keeps event detection, stamping and drop accounting.

Test Plan:
- Reset, then reg write $8 = 5 at pc 0x0 on the first edge, out_ready=1 → next cycle: out_valid=1, kind=01, cycle=0, pc=0, addr=8, data=5; out_valid drops after one pop.
- Write to $0 (register_we3=1, a3=0, wd3=7) → no entry; out_valid stays 0; drop_count=0.
- sw to address 0x10 with data 42 at pc 0x14, sampled at the 6th edge after reset → kind=10, addr=0x10, data=42, pc=0x14, cycle=5.
- DEPTH=16, out_ready=0, 18 consecutive reg writes → out_valid=1, 16 entries held, overflow=1, drop_count=2. Then drain with out_ready=1: 16 pops in original order, cycle stamps strictly increasing by 1.
- count=15, reg and mem events in the same cycle → reg entry pushed, mem entry dropped, drop_count+1. Repeat at count=14 → both pushed, reg entry ahead of mem entry.
- Assert reset for 1 ns between edges while 5 entries are queued → out_valid=0 and overflow=0 immediately. The next event is stamped cycle 0.
